// File: rtl/pixel_pkg.sv
// Shared constants, frame-buffer entry type and address helper for the pixel-plot path.
package pixel_pkg;

    localparam int unsigned WIDTH      = 160;
    localparam int unsigned HEIGHT     = 120;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DROP_W     = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_entry_t;

    // Linear address y*160 + x built from shifts (160 = 128 + 32).
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with same-cycle push and pop; head word is presented combinationally.
module pixel_fifo #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 18,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Entry storage; occupancy is tracked by count so the array needs no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Pixel-plot receiver: range check, write buffering and read-priority frame-buffer port arbitration.
module pixel_sink
    import pixel_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                plot_in,
    output logic                plot_ready,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_wdata,
    output logic                mem_we,
    input  logic [COLOUR_W-1:0] mem_rdata,
    output logic                frame_done,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(pixel_entry_t);

    logic               in_range;
    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   fifo_count;
    pixel_entry_t       push_entry;
    pixel_entry_t       head;
    logic [ENTRY_W-1:0] head_word;
    logic               rd_pending;

    // Request handshake and on-screen classification.
    assign plot_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign in_range   = (x_in < X_W'(WIDTH)) && (y_in < Y_W'(HEIGHT));
    assign accept     = plot_in && !full;
    assign push       = accept && in_range;
    assign drop       = accept && !in_range;
    assign push_entry = '{addr: pixel_addr(x_in, y_in), colour: colour_in};

    // Reads own the port; the buffer drains only in cycles without a read request.
    assign pop  = !rd_req && !empty;
    assign head = pixel_entry_t'(head_word);

    // Read data is only meaningful while rd_valid is high, so mask it otherwise.
    assign rd_colour = rd_valid ? mem_rdata : '0;

    pixel_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_word),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Memory port registers: read address, popped write, or hold address/data when idle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
        end else if (rd_req) begin
            mem_addr   <= rd_addr;
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
        end else if (!empty) begin
            mem_addr   <= head.addr;
            mem_wdata  <= head.colour;
            mem_we     <= 1'b1;
            frame_done <= (head.addr == LAST_ADDR);
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    // Read-return pipeline matching the RAM's one-cycle read latency.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_pending <= rd_req;
            rd_valid   <= rd_pending;
        end
    end

    // Saturating count of off-screen requests.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule
